// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller for the 8-bit accumulator CPU: steps the 8-phase
// fetch/execute sequence and decodes the control strobes for the datapath.
module cpu_sequencer (
    input  logic       clk1,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_acc,
    output logic       load_ir,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_HALT
    } state_t;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    state_t state_q, state_d;
    logic   skip_q, skip_d;
    logic   is_alu;

    // Opcodes that fetch an operand and write the accumulator.
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                    (opcode == OP_XORR) || (opcode == OP_LDA);

    always_ff @(posedge clk1) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        load_ir     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        phase       = 3'd0;
        case (state_q)
            ST_IDLE: if (ena) state_d = ST_S0;
            ST_S0: begin
                phase   = 3'd0;
                rd      = 1'b1;
                load_ir = 1'b1;
                state_d = ST_S1;
            end
            ST_S1: begin
                phase   = 3'd1;
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
                state_d = ST_S2;
            end
            ST_S2: begin
                phase   = 3'd2;
                state_d = ST_S3;
            end
            ST_S3: begin
                phase   = 3'd3;
                inc_pc  = 1'b1;
                state_d = ST_S4;
            end
            ST_S4: begin
                phase   = 3'd4;
                state_d = (opcode == OP_HLT) ? ST_HALT : ST_S5;
            end
            ST_S5: begin
                phase   = 3'd5;
                rd      = is_alu;
                state_d = ST_S6;
            end
            ST_S6: begin
                phase       = 3'd6;
                rd          = is_alu;
                load_acc    = is_alu;
                load_pc     = (opcode == OP_JMP);
                datactl_ena = (opcode == OP_STO);
                if (opcode == OP_SKZ) skip_d = zero;
                state_d     = ST_S7;
            end
            ST_S7: begin
                phase       = 3'd7;
                wr          = (opcode == OP_STO);
                datactl_ena = (opcode == OP_STO);
                inc_pc      = (opcode == OP_SKZ) && skip_q;
                state_d     = ena ? ST_S0 : ST_IDLE;
            end
            ST_HALT: halt = 1'b1;  // sticky; only reset leaves
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_S0) skip_d = 1'b0;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; strobe vector order is
// {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena}.
module tb_cpu_sequencer;

    logic       clk1 = 1'b0;
    logic       rst, ena, zero;
    logic [2:0] opcode;
    logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
    logic [2:0] phase;
    int         total = 0;
    int         bad = 0;

    cpu_sequencer dut (
        .clk1(clk1), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc), .load_ir(load_ir),
        .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .phase(phase)
    );

    always #5 clk1 = ~clk1;

    wire [7:0]  obs = {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena};
    wire [10:0] obs_all = {obs, phase};

    // Fetch part of every instruction, S0..S4.
    localparam logic [7:0] F0 = 8'h0C, F1 = 8'h4C, F2 = 8'h00, F3 = 8'h40, F4 = 8'h00;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ena = 1'b0; opcode = 3'b000; zero = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; opcode = 3'b101; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs_all !== 11'd0) begin
                bad++; $display("FAIL reset_hold cyc=%0d got=%h want=000", i, obs_all);
            end
        end
        rst = 1'b1; ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs_all !== 11'd0) begin
                bad++; $display("FAIL idle cyc=%0d got=%h want=000", i, obs_all);
            end
        end
    endtask

    task automatic test_lda();
        logic [7:0] e [8] = '{F0, F1, F2, F3, F4, 8'h04, 8'h14, 8'h00};
        do_reset();
        ena = 1'b1; opcode = 3'b101;
        for (int p = 0; p < 9; p++) begin
            tick();
            total++;
            if (obs_all !== {e[p % 8], 3'(p % 8)}) begin
                bad++; $display("FAIL lda p=%0d got=%h want=%h", p, obs_all, {e[p % 8], 3'(p % 8)});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e [16] = '{F0, F1, F2, F3, F4, 8'h00, 8'h01, 8'h03,
                               F0, F1, F2, F3, F4, 8'h00, 8'h20, 8'h00};
        do_reset();
        ena = 1'b1; opcode = 3'b110;
        for (int p = 0; p < 16; p++) begin
            tick();
            if (p == 8) opcode = 3'b111;
            if (p == 10) ena = 1'b0;
            #1;
            total++;
            if (obs_all !== {e[p], 3'(p % 8)}) begin
                bad++; $display("FAIL sto_jmp p=%0d got=%h want=%h", p, obs_all, {e[p], 3'(p % 8)});
            end
        end
        tick();
        total++;
        if (obs_all !== 11'd0) begin
            bad++; $display("FAIL sto_jmp_end got=%h want=000", obs_all);
        end
    endtask

    task automatic test_skz(input logic z);
        logic [7:0] e7;
        e7 = z ? 8'h40 : 8'h00;
        do_reset();
        ena = 1'b1; opcode = 3'b001; zero = ~z;
        for (int p = 0; p < 8; p++) begin
            tick();
            if (p == 6) zero = z;
            if (p == 7) zero = ~z;
            #1;
            total++;
            if (obs_all !== {(p == 7) ? e7 : (p < 5 ? 8'(p == 0 || p == 1 ? 8'h0C | (p == 1 ? 8'h40 : 8'h00) : (p == 3 ? 8'h40 : 8'h00)) : 8'h00), 3'(p)}) begin
                bad++; $display("FAIL skz z=%0d p=%0d got=%h", z, p, obs_all);
            end
            if (p == 7) ena = 1'b0;
        end
    endtask

    task automatic test_halt();
        logic [7:0] e [5] = '{F0, F1, F2, F3, F4};
        do_reset();
        ena = 1'b1; opcode = 3'b000; zero = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick();
            total++;
            if (obs_all !== {e[p], 3'(p)}) begin
                bad++; $display("FAIL hlt p=%0d got=%h want=%h", p, obs_all, {e[p], 3'(p)});
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            opcode = 3'(i);
            #1;
            total++;
            if (obs_all !== {8'h80, 3'd0}) begin
                bad++; $display("FAIL halted cyc=%0d got=%h want=400", i, obs_all);
            end
        end
        rst = 1'b0;
        tick();
        rst = 1'b1; ena = 1'b0;
        total++;
        if (obs_all !== 11'd0) begin
            bad++; $display("FAIL halt_reset got=%h want=000", obs_all);
        end
        tick();
        total++;
        if (obs_all !== 11'd0) begin
            bad++; $display("FAIL halt_reset_idle got=%h want=000", obs_all);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_acc = 1'b0;
        do_reset();
        ena = 1'b1; opcode = 3'b010;
        for (int p = 0; p < 6; p++) begin
            tick();
            seen_acc |= load_acc;
        end
        total++;
        if (phase !== 3'd5) begin
            bad++; $display("FAIL mid_s5 got=%0d want=5", phase);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1; ena = 1'b0;
        seen_acc |= load_acc;
        total++;
        if (obs_all !== 11'd0) begin
            bad++; $display("FAIL mid_reset got=%h want=000", obs_all);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_acc |= load_acc;
        end
        total++;
        if (seen_acc !== 1'b0) begin
            bad++; $display("FAIL mid_load_acc got=%b want=0", seen_acc);
        end
    endtask

    task automatic test_ena_drop();
        logic [7:0] e [8] = '{F0, F1, F2, F3, F4, 8'h04, 8'h14, 8'h00};
        do_reset();
        ena = 1'b1; opcode = 3'b010;
        for (int p = 0; p < 8; p++) begin
            tick();
            if (p == 3) ena = 1'b0;
            #1;
            total++;
            if (obs_all !== {e[p], 3'(p)}) begin
                bad++; $display("FAIL ena_drop p=%0d got=%h want=%h", p, obs_all, {e[p], 3'(p)});
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs_all !== 11'd0) begin
                bad++; $display("FAIL ena_drop_idle cyc=%0d got=%h want=000", i, obs_all);
            end
        end
        ena = 1'b1;
        tick();
        total++;
        if (obs_all !== {F0, 3'd0}) begin
            bad++; $display("FAIL restart got=%h want=%h", obs_all, {F0, 3'd0});
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_back_to_back();
        test_skz(1'b1);
        test_skz(1'b0);
        test_halt();
        test_reset_mid();
        test_ena_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle controller for the 8-bit accumulator CPU. It steps an 8-phase fetch/execute sequence and drives the control strobes for the rest of the core:
- PC increment/load
- instruction-register load
- memory read/write
- data-bus driver enable
- accumulator load enable (the `ena` input of the accumulator register)

It sits between the instruction register (opcode, zero flag) and the datapath. It adds start/stop gating and a sticky halt state.

## Interface
- No parameters. Opcode width is fixed at 3 bits and the phase count is fixed at 8.
- `clk1` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset (sampled on rising `clk1`; 0 = reset).
- `ena` in 1: run enable. 1 = start or continue issuing instructions.
- `opcode` in 3: instruction-register opcode. Must be stable from phase S2 to S7.
  - 000 HLT, 001 SKZ, 010 ADD, 011 ANDD, 100 XORR, 101 LDA, 110 STO, 111 JMP.
- `zero` in 1: accumulator-is-zero flag.
- `inc_pc` out 1: PC increment strobe.
- `load_pc` out 1: PC load from the instruction address field.
- `load_acc` out 1: accumulator load enable.
- `load_ir` out 1: instruction-register load (high then low byte).
- `rd` out 1: memory read.
- `wr` out 1: memory write.
- `datactl_ena` out 1: drive accumulator/ALU result onto the data bus.
- `halt` out 1: 1 while halted.
- `phase` out 3: current phase S0–S7 (debug). Reads 0 in IDLE and HALT.

## Operation
- States are IDLE, S0–S7 and HALT. The state register resets to IDLE.
- One-bit register `skip_r` latches the SKZ decision.
- Strobe outputs are combinational decodes of state, `opcode` and `skip_r`. Each phase below lists the strobes that are 1; all others are 0.
  - IDLE: none. Go to S0 when `ena`=1, else stay in IDLE.
  - S0: `rd`, `load_ir` (fetch high byte).
  - S1: `rd`, `load_ir`, `inc_pc` (fetch low byte).
  - S2: none (opcode settles).
  - S3: `inc_pc`.
  - S4: none for every opcode.
    - If HLT, the next state is HALT.
    - Otherwise the next state is S5.
  - S5: `rd` if opcode is ADD, ANDD, XORR or LDA (operand fetch).
  - S6, by opcode:
    - ADD, ANDD, XORR, LDA: `rd` and `load_acc`.
    - JMP: `load_pc`.
    - STO: `datactl_ena`.
    - SKZ: no strobe. `skip_r` is set to `zero`, sampled at the end of S6.
  - S7, by opcode:
    - STO: `wr` and `datactl_ena`.
    - SKZ: `inc_pc` if `skip_r`=1.
  - S7 next state: S0 if `ena`=1, else IDLE.
  - HALT: `halt`=1 and every other strobe is 0. The only exit is reset.
- `skip_r` is cleared on reset and on every entry to S0.
- Dropping `ena` mid-instruction has no effect until the S7→next transition; the current instruction always completes.
- `opcode` and `zero` are ignored in IDLE, S0–S3 and HALT.

## Timing
- Reset (`rst`=0 at an edge): the state becomes IDLE at that edge, whatever the current state, including mid-instruction and HALT.
- Reset values of all outputs: `inc_pc`, `load_pc`, `load_acc`, `load_ir`, `rd`, `wr`, `datactl_ena`, `halt` = 0; `phase` = 0.
- Start latency: `ena` sampled 1 at edge k in IDLE puts the block in S0 during cycle k+1.
- Instruction length is exactly 8 cycles, except HLT, which takes 5 (S0–S4) and then enters HALT.
- Back-to-back instructions with `ena` held at 1 have no idle cycle between S7 and S0.
- Per instruction:
  - `load_acc` is high for exactly one cycle (S6), and only for ADD, ANDD, XORR, LDA. The accumulator captures the data at the edge ending S6.
  - `wr` is high only in S7 of STO.
  - `wr` and `rd` are never high together.
- Strobes are glitch-free from the datapath's view: inputs are required stable within a phase.

## Test plan
- Reset/idle: `rst`=0 for 2 cycles, then `rst`=1 with `ena`=0 for 5 cycles → all outputs 0, `phase`=0 throughout.
- LDA: `ena`=1, `opcode`=101 → S0–S7 sequence with `rd` in S0, S1, S5, S6; `inc_pc` in S1, S3; `load_acc` only in S6; next cycle is S0.
- STO then JMP back-to-back:
  - STO: `datactl_ena` in S6–S7, `wr` only in S7.
  - JMP: `load_pc` only in S6.
  - Total 16 cycles with no gap.
- SKZ:
  - `zero`=1 in S6 → `inc_pc` in S7.
  - Repeat with `zero`=0 → no `inc_pc` in S7.
  - Toggling `zero` during S7 does not change the result.
- HLT and mid-instruction behaviour:
  - `opcode`=000 → `halt`=1 from cycle 6 onward, indefinitely, with `ena`=1 still held and no strobes. `rst`=0 for one edge → IDLE.
  - Reset during S5 of an ADD → IDLE next cycle, `load_acc` never asserted.
- `ena` dropped in S3 of an ADD → instruction completes (`load_acc` in S6), then IDLE. Re-raising `ena` → S0 one cycle later.
